// File: rtl/button_pkg.sv
// Shared types for the button handler: read FSM states and the code-width helper.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    CLEAR = 2'd2
  } rd_state_e;

  // Width of a press code: channel index+1, with 0 reserved for "none".
  function automatic int cw_of(input int n_btn);
    return $clog2(n_btn + 1);
  endfunction

endpackage

// File: rtl/button_handler_debounce.sv
// One button channel: 2-flop synchroniser, pulse_en-paced debounce counter,
// accepted (stable) level and a one-clk press pulse on a stable 0->1 change.
module btn_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic pulse_en_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNTW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(DEB_TICKS - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            press_q, press_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  assign press_o = press_q;

  // Debounce next state: any agreement with the stable level restarts the count.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    press_d  = 1'b0;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (pulse_en_i) begin
      if (cnt_q == LAST) begin
        stable_d = ~stable_q;
        cnt_d    = '0;
        press_d  = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNTW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Synchroniser and debounce state registers.
  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

endmodule

// File: rtl/button_handler.sv
// Debounced button press latch with a three-step processor read handshake.
// Define BTN_FIFO_EN to queue presses in a FIFO_DEPTH-entry FIFO instead of one code register.
module button_handler
  import button_pkg::*;
#(
  parameter int         N_BTN      = 3,
  parameter int         DEB_TICKS  = 4,
  parameter logic [2:0] RD_OFFSET  = 3'b001,
  parameter int         FIFO_DEPTH = 4,
  localparam int        CW         = cw_of(N_BTN)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             pulse_en,
  input  logic [31:0]      addr,
  input  logic [N_BTN-1:0] buttons,
  output logic [CW-1:0]    btn_val,
  output logic             btn_valid,
  output logic             btn_ovf
);

  logic [N_BTN-1:0] press_s;
  logic [CW-1:0]    win_code_s;
  logic             any_press_s, multi_s, rd_hit_s, consume_s, drop_s;
  logic [CW-1:0]    val_d, btn_val_q;
  logic             btn_valid_q, btn_ovf_q, ovf_d;
  rd_state_e        state_q, state_d;
  logic             addr_unused_s;

  assign addr_unused_s = ^{addr[31:24], addr[22:3]};

  for (genvar g = 0; g < N_BTN; g++) begin : g_deb
    btn_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clk_i      (clk),
      .clr_i      (clr),
      .pulse_en_i (pulse_en),
      .btn_i      (buttons[g]),
      .press_o    (press_s[g])
    );
  end

  assign any_press_s = |press_s;
  assign multi_s     = |(press_s & (press_s - N_BTN'(1)));
  assign rd_hit_s    = addr[23] && (addr[2:0] == RD_OFFSET);

  // Lowest-index press wins; scanning downwards leaves the lowest one last.
  always_comb begin
    win_code_s = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (press_s[i]) begin
        win_code_s = CW'(i + 1);
      end else begin
        win_code_s = win_code_s;
      end
    end
  end

  // Read FSM; consume_s marks the CLEAR->IDLE step that retires the pending code.
  always_comb begin
    state_d   = state_q;
    consume_s = 1'b0;
    if (pulse_en) begin
      case (state_q)
        IDLE:    state_d = rd_hit_s ? HOLD : IDLE;
        HOLD:    state_d = CLEAR;
        CLEAR: begin
          state_d   = IDLE;
          consume_s = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end else begin
      state_d = state_q;
    end
  end

`ifdef BTN_FIFO_EN
  localparam int PW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          empty_s, full_s, pop_s, push_s;

  assign empty_s = (wr_ptr_q == rd_ptr_q);
  assign full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign pop_s   = consume_s && !empty_s;
  assign push_s  = any_press_s && (!full_s || pop_s);
  assign drop_s  = multi_s || (any_press_s && !push_s);

  // Pointer update and look-ahead of the head so btn_val tracks the queue with no lag.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (push_s ? PW'(1) : PW'(0));
    rd_ptr_d = rd_ptr_q + (pop_s ? PW'(1) : PW'(0));
    if (rd_ptr_d == wr_ptr_d) begin
      val_d = '0;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      val_d = win_code_s;
    end else begin
      val_d = mem_q[rd_ptr_d[PW-2:0]];
    end
  end

  // Queue storage.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[PW-2:0]] <= win_code_s;
    end else begin
      mem_q[wr_ptr_q[PW-2:0]] <= mem_q[wr_ptr_q[PW-2:0]];
    end
  end

  // Queue pointers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
`else
  localparam int fifo_depth_unused = FIFO_DEPTH;

  assign drop_s = multi_s || (any_press_s && (state_q != IDLE));

  // Single code register: newest press in IDLE overwrites, a read retires it.
  always_comb begin
    val_d = btn_val_q;
    if (any_press_s && (state_q == IDLE)) begin
      val_d = win_code_s;
    end else if (consume_s) begin
      val_d = '0;
    end else begin
      val_d = btn_val_q;
    end
  end
`endif

  // A drop in the same cycle as a completed read still leaves the flag set.
  always_comb begin
    ovf_d = btn_ovf_q;
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (consume_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = btn_ovf_q;
    end
  end

  // Output and FSM registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= IDLE;
      btn_val_q   <= '0;
      btn_valid_q <= 1'b0;
      btn_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_val_q   <= val_d;
      btn_valid_q <= (val_d != '0);
      btn_ovf_q   <= ovf_d;
    end
  end

  assign btn_val   = btn_val_q;
  assign btn_valid = btn_valid_q;
  assign btn_ovf   = btn_ovf_q;

endmodule

// File: tb/tb_button_handler.sv
// Self-checking bench for button_handler: directed scenarios plus random steps
// checked against a step-level behavioural model of presses, reads and drops.
module tb_button_handler;

  localparam int N_BTN      = 3;
  localparam int DEB_TICKS  = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = 2;
  localparam logic [31:0] RD_ADDR = 32'h0080_0001;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic             pulse_en = 1'b0;
  logic [31:0]      addr = 32'h0;
  logic [N_BTN-1:0] buttons = '0;
  logic [CW-1:0]    btn_val;
  logic             btn_valid;
  logic             btn_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: accepted level and consecutive-tick count per pin, pending codes,
  // read progress (0 idle, 1 holding, 2 clearing) and the sticky drop flag.
  bit stable_m [N_BTN];
  int cnt_m    [N_BTN];
  int q_m [$];
  int phase_m;
  bit ovf_m;
  logic [CW-1:0] early_val, mid_val;

  button_handler #(
    .N_BTN(N_BTN), .DEB_TICKS(DEB_TICKS), .RD_OFFSET(3'b001), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .clr(clr), .pulse_en(pulse_en), .addr(addr), .buttons(buttons),
    .btn_val(btn_val), .btn_valid(btn_valid), .btn_ovf(btn_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_BTN; i++) begin
      stable_m[i] = 1'b0;
      cnt_m[i]    = 0;
    end
    q_m.delete();
    phase_m = 0;
    ovf_m   = 1'b0;
  endtask

  function automatic int exp_val();
    return (q_m.size() > 0) ? q_m[0] : 0;
  endfunction

  // One pulse_en tick with the given pin levels and address.
  task automatic model_tick(input logic [N_BTN-1:0] raw, input logic [31:0] a);
    bit dec;
    int winner;
    dec = a[23] && (a[2:0] == 3'b001);
    if (phase_m == 0) begin
      if (dec) phase_m = 1;
    end else if (phase_m == 1) begin
      phase_m = 2;
    end else begin
      phase_m = 0;
      if (q_m.size() > 0) void'(q_m.pop_front());
      ovf_m = 1'b0;
    end
    winner = 0;
    for (int i = 0; i < N_BTN; i++) begin
      if (raw[i] != stable_m[i]) begin
        cnt_m[i]++;
        if (cnt_m[i] == DEB_TICKS) begin
          stable_m[i] = raw[i];
          cnt_m[i]    = 0;
          if (raw[i]) begin
            if (winner == 0) winner = i + 1;
            else ovf_m = 1'b1;
          end
        end
      end else begin
        cnt_m[i] = 0;
      end
    end
    if (winner != 0) begin
`ifdef BTN_FIFO_EN
      if (q_m.size() < FIFO_DEPTH) q_m.push_back(winner);
      else ovf_m = 1'b1;
`else
      if (phase_m == 0) begin
        q_m.delete();
        q_m.push_back(winner);
      end else begin
        ovf_m = 1'b1;
      end
`endif
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".val"},   32'(btn_val),   32'(exp_val()));
    check({tag, ".valid"}, 32'(btn_valid), 32'(exp_val() != 0));
    check({tag, ".ovf"},   32'(btn_ovf),   32'(ovf_m));
  endtask

  // Settle pins through the synchroniser, fire one tick, let the result land, check.
  task automatic step(input logic [N_BTN-1:0] b, input logic [31:0] a, input string tag);
    @(negedge clk);
    buttons  = b;
    pulse_en = 1'b0;
    addr     = 32'h0;
    repeat (3) @(negedge clk);
    pulse_en = 1'b1;
    addr     = a;
    @(negedge clk);
    pulse_en  = 1'b0;
    addr      = 32'h0;
    early_val = btn_val;
    @(negedge clk);
    mid_val = btn_val;
    repeat (2) @(negedge clk);
    model_tick(b, a);
    check_outputs(tag);
  endtask

  task automatic steps(input int n, input logic [N_BTN-1:0] b, input string tag);
    for (int i = 0; i < n; i++) step(b, 32'h0, tag);
  endtask

  task automatic do_read(input string tag);
    step(buttons, RD_ADDR, {tag, ".hold"});
    step(buttons, 32'h0, {tag, ".clear"});
    step(buttons, 32'h0, {tag, ".idle"});
  endtask

  initial begin
    logic [N_BTN-1:0] rb;
    logic [31:0]      ra;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset.val",   32'(btn_val),   32'h0);
    check("reset.valid", 32'(btn_valid), 32'h0);
    check("reset.ovf",   32'(btn_ovf),   32'h0);
    clr = 1'b0;

    steps(3, 3'b010, "press2.early");
    step(3'b010, 32'h0, "press2.tick4");
    check("press2.before", 32'(early_val), 32'h0);
`ifndef BTN_FIFO_EN
    check("press2.latency", 32'(mid_val), 32'h2);
`endif
    check("press2.val",   32'(btn_val),   32'h2);
    check("press2.valid", 32'(btn_valid), 32'h1);
    steps(4, 3'b000, "release2");
    steps(3, 3'b100, "glitch");
    steps(4, 3'b000, "glitch.gone");
    check("glitch.val", 32'(btn_val), 32'h2);

    step(3'b000, RD_ADDR, "read.hold");
    check("read.hold.val", 32'(btn_val), 32'h2);
    step(3'b000, 32'h0, "read.clear");
    check("read.clear.val", 32'(btn_val), 32'h2);
    step(3'b000, 32'h0, "read.idle");
    check("read.idle.val", 32'(btn_val), 32'h0);
    check("read.idle.ovf", 32'(btn_ovf), 32'h0);
    do_read("read.empty");

    steps(4, 3'b101, "multi");
    check("multi.val", 32'(btn_val), 32'h1);
    check("multi.ovf", 32'(btn_ovf), 32'h1);
    steps(4, 3'b000, "multi.release");
    do_read("multi.read");
`ifdef BTN_FIFO_EN
    do_read("multi.read2");
`endif

`ifndef BTN_FIFO_EN
    steps(4, 3'b001, "hold.press1");
    steps(4, 3'b000, "hold.release1");
    steps(3, 3'b010, "hold.pre2");
    step(3'b010, RD_ADDR, "hold.press2");
    check("hold.drop.val", 32'(btn_val), 32'h1);
    check("hold.drop.ovf", 32'(btn_ovf), 32'h1);
    step(3'b010, 32'h0, "hold.clear");
    step(3'b010, 32'h0, "hold.idle");
    check("hold.idle.ovf", 32'(btn_ovf), 32'h0);
    check("hold.idle.val", 32'(btn_val), 32'h0);
    steps(4, 3'b000, "hold.release2");
`else
    for (int k = 0; k < 5; k++) begin
      rb = 3'(1 << (k % 3));
      steps(4, rb, "fifo.push");
      steps(4, 3'b000, "fifo.release");
    end
    check("fifo.full.ovf", 32'(btn_ovf), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step(3'b000, RD_ADDR, "fifo.read.hold");
      check("fifo.read.val", 32'(btn_val), 32'((k < 4) ? ((k % 3) + 1) : 0));
      step(3'b000, 32'h0, "fifo.read.clear");
      step(3'b000, 32'h0, "fifo.read.idle");
    end
`endif

    steps(4, 3'b100, "clr.press3");
    step(3'b100, RD_ADDR, "clr.hold");
`ifndef BTN_FIFO_EN
    check("clr.hold.val", 32'(btn_val), 32'h3);
`endif
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    check("clr.async.val",   32'(btn_val),   32'h0);
    check("clr.async.valid", 32'(btn_valid), 32'h0);
    check("clr.async.ovf",   32'(btn_ovf),   32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    clr = 1'b0;
    steps(3, 3'b100, "clr.after");
    check("clr.noevent", 32'(btn_val), 32'h0);
    step(3'b100, 32'h0, "clr.full");
    check("clr.full.val", 32'(btn_val), 32'h3);
    do_read("clr.read");

    for (int k = 0; k < 300; k++) begin
      rb = buttons;
      if ($urandom_range(3) == 0) rb = N_BTN'($urandom);
      ra = $urandom;
      if ($urandom_range(2) == 0) ra = (ra & 32'hFFFF_FFF8) | 32'h0080_0001;
      step(rb, ra, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/button_handler.md
BUTTON_HANDLER -- requirements
Module: button_handler

Interface
REQ-001 Parameter N_BTN, 3: number of button channels, range 1..15.
REQ-002 Parameter DEB_TICKS, 4: number of consecutive pulse_en ticks a changed level must persist before it is accepted, range 1..255.
REQ-003 Parameter RD_OFFSET, 3'b001: addr[2:0] value that decodes a processor read.
REQ-004 Parameter FIFO_DEPTH, 4: event queue depth, power of two, 2..16; used only with BTN_FIFO_EN.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 clr  in  1  reset, asynchronous, active-high.
REQ-007 pulse_en  in  1  timebase strobe; debounce and FSM advance only when it is high.
REQ-008 addr  in  32  processor address bus.
REQ-009 buttons  in  N_BTN  raw asynchronous button pins, active-high.
REQ-010 btn_val  out  CW=$clog2(N_BTN+1)  pending press code: channel index+1, or 0 if none pending.
REQ-011 btn_valid  out  1  high when btn_val is nonzero.
REQ-012 btn_ovf  out  1  sticky: a press was dropped since the last completed read.

Function
REQ-013 Each button SHALL pass through a 2-flop synchroniser before any other logic.
REQ-014 Debounce per channel: counter clears when the synced level equals the stable level; on pulse_en with differing levels it increments; when it reaches DEB_TICKS-1 on pulse_en, the stable level flips and the counter clears.
REQ-015 A press event SHALL be a stable 0->1 transition, one clk wide; releases generate no event.
REQ-016 Simultaneous press events in one cycle: lowest index wins, code = index+1; all others are dropped and set btn_ovf.
REQ-017 Read FSM states IDLE, HOLD, CLEAR; transitions only on pulse_en.
REQ-018 IDLE->HOLD when addr[23]=1 and addr[2:0]=RD_OFFSET; otherwise stay in IDLE.
REQ-019 HOLD->CLEAR unconditionally; btn_val SHALL stay unchanged through HOLD so the processor can sample it.
REQ-020 CLEAR->IDLE unconditionally; on this transition the pending code is consumed and btn_ovf clears.
REQ-021 btn_val, btn_valid and btn_ovf SHALL be driven directly from registers, with no combinational path from inputs.
REQ-022 A read decoded with nothing pending SHALL still walk IDLE->HOLD->CLEAR->IDLE and return 0.

Reset
REQ-023 clr SHALL force the following: synchronisers and stable levels 0, debounce counters 0, FSM IDLE, btn_val 0, btn_valid 0, btn_ovf 0, FIFO empty.
REQ-024 clr asserted mid-debounce or mid-read SHALL discard the partial state; no event is produced after release until a full debounce period completes.

Configuration
REQ-025 Macro BTN_FIFO_EN undefined: pending storage is a single code register, loaded only in IDLE (newest press overwrites the previous one); a press in HOLD or CLEAR is dropped and sets btn_ovf.
REQ-026 Macro BTN_FIFO_EN defined: pending storage is a FIFO_DEPTH-entry queue with btn_val = head code (0 if empty); pushes are accepted in any FSM state; the head is popped on CLEAR->IDLE.
REQ-027 With BTN_FIFO_EN, a push to a full queue is dropped and sets btn_ovf; if a pop and a push occur in the same cycle while full, both are accepted.
REQ-028 With BTN_FIFO_EN, pointers SHALL be $clog2(FIFO_DEPTH)+1 bits wide and wrap modulo 2*FIFO_DEPTH.

Structure
REQ-029 Package button_pkg SHALL hold the FSM state enum (IDLE=0, HOLD=1, CLEAR=2) and the CW width helper function.
REQ-030 A per-channel sub-module btn_debounce (synchroniser, counter, stable level, press pulse) SHALL be instantiated N_BTN times via generate.

Verification
REQ-031 N_BTN=3, DEB_TICKS=4: hold buttons=3'b010 for 4 pulse_en ticks -> btn_val=2 and btn_valid=1 one cycle after the 4th tick; a 3-tick glitch -> no event.
REQ-032 With btn_val=2, drive addr=32'h0080_0001 on a pulse_en -> btn_val=2 through HOLD, then 0 after CLEAR->IDLE, btn_ovf=0.
REQ-033 Pins 3'b101 debounce in the same cycle -> btn_val=1, btn_ovf=1.
REQ-034 No macro: a press of channel 2 during HOLD -> dropped, btn_ovf=1, btn_val unchanged; btn_ovf clears on CLEAR->IDLE.
REQ-035 BTN_FIFO_EN, FIFO_DEPTH=4: presses 1,2,3,1,2 -> 5th dropped, btn_ovf=1; successive reads return 1,2,3,1, then 0.
REQ-036 Assert clr during HOLD with btn_val=3 -> all outputs 0 immediately (asynchronous), FSM IDLE.
